// File: rtl/axi_mem_bist_master.sv
// AXI4 write-then-readback memory self-test initiator.
// Each run writes NUM_BURSTS INCR bursts of {~addr, addr} patterns, then reads them back and checks them.
// The result is reported as pass/done plus a saturating error count and the first failing byte address.
module axi_mem_bist_master #(
   parameter int unsigned       ID_W       = 4,
   parameter logic [ID_W-1:0]   TXN_ID     = 4'h3,
   parameter int unsigned       BURST_LEN  = 8,
   parameter int unsigned       NUM_BURSTS = 1024,
   parameter logic [31:0]       BASE_ADDR  = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       error_count,
   output logic [31:0]       first_fail_addr,
   output logic              io_axi4_0_aw_valid,
   input  logic              io_axi4_0_aw_ready,
   output logic [ID_W-1:0]   io_axi4_0_aw_id,
   output logic [31:0]       io_axi4_0_aw_addr,
   output logic [7:0]        io_axi4_0_aw_len,
   output logic [2:0]        io_axi4_0_aw_size,
   output logic [1:0]        io_axi4_0_aw_burst,
   output logic              io_axi4_0_aw_lock,
   output logic [3:0]        io_axi4_0_aw_cache,
   output logic [2:0]        io_axi4_0_aw_prot,
   output logic [3:0]        io_axi4_0_aw_qos,
   output logic              io_axi4_0_w_valid,
   input  logic              io_axi4_0_w_ready,
   output logic [63:0]       io_axi4_0_w_data,
   output logic [7:0]        io_axi4_0_w_strb,
   output logic              io_axi4_0_w_last,
   input  logic              io_axi4_0_b_valid,
   output logic              io_axi4_0_b_ready,
   input  logic [ID_W-1:0]   io_axi4_0_b_id,
   input  logic [1:0]        io_axi4_0_b_resp,
   output logic              io_axi4_0_ar_valid,
   input  logic              io_axi4_0_ar_ready,
   output logic [ID_W-1:0]   io_axi4_0_ar_id,
   output logic [31:0]       io_axi4_0_ar_addr,
   output logic [7:0]        io_axi4_0_ar_len,
   output logic [2:0]        io_axi4_0_ar_size,
   output logic [1:0]        io_axi4_0_ar_burst,
   output logic              io_axi4_0_ar_lock,
   output logic [3:0]        io_axi4_0_ar_cache,
   output logic [2:0]        io_axi4_0_ar_prot,
   output logic [3:0]        io_axi4_0_ar_qos,
   input  logic              io_axi4_0_r_valid,
   output logic              io_axi4_0_r_ready,
   input  logic [ID_W-1:0]   io_axi4_0_r_id,
   input  logic [63:0]       io_axi4_0_r_data,
   input  logic [1:0]        io_axi4_0_r_resp,
   input  logic              io_axi4_0_r_last
);

   localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
   localparam logic [8:0]  LAST_BEAT   = 9'(BURST_LEN - 1);
   localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);

   typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE} state_e;

   state_e       state_q;
   logic [31:0]  burstAddr_q;
   logic [31:0]  burstCnt_q;
   logic [8:0]   beatCnt_q;
   logic         busy_q, done_q, pass_q;
   logic [15:0]  errorCount_q;
   logic [31:0]  firstFail_q;
   logic         awValid_q, wValid_q, bReady_q, arValid_q, rReady_q;

   logic [31:0]  beatAddr;
   logic [63:0]  beatPattern;
   logic         isLastBeat, moreBursts, bBad, rBad;
   logic [15:0]  errorCountInc;

   // Derived beat address/pattern and the per-response failure conditions.
   assign beatAddr      = burstAddr_q + {20'b0, beatCnt_q, 3'b000};
   assign beatPattern   = {~beatAddr, beatAddr};
   assign isLastBeat    = (beatCnt_q == LAST_BEAT);
   assign moreBursts    = (burstCnt_q != LAST_BURST);
   assign bBad          = (io_axi4_0_b_resp != 2'b00) || (io_axi4_0_b_id != TXN_ID);
   assign rBad          = (io_axi4_0_r_data != beatPattern) || (io_axi4_0_r_resp != 2'b00) ||
                          (io_axi4_0_r_id != TXN_ID) || (io_axi4_0_r_last != isLastBeat);
   assign errorCountInc = (errorCount_q == 16'hFFFF) ? errorCount_q : errorCount_q + 16'd1;

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign error_count     = errorCount_q;
   assign first_fail_addr = firstFail_q;

   assign io_axi4_0_aw_valid = awValid_q;
   assign io_axi4_0_aw_id    = TXN_ID;
   assign io_axi4_0_aw_addr  = burstAddr_q;
   assign io_axi4_0_aw_len   = 8'(BURST_LEN - 1);
   assign io_axi4_0_aw_size  = 3'b011;
   assign io_axi4_0_aw_burst = 2'b01;
   assign io_axi4_0_aw_lock  = 1'b0;
   assign io_axi4_0_aw_cache = 4'b0011;
   assign io_axi4_0_aw_prot  = 3'b000;
   assign io_axi4_0_aw_qos   = 4'b0000;
   assign io_axi4_0_w_valid  = wValid_q;
   assign io_axi4_0_w_data   = beatPattern;
   assign io_axi4_0_w_strb   = 8'hFF;
   assign io_axi4_0_w_last   = isLastBeat;
   assign io_axi4_0_b_ready  = bReady_q;
   assign io_axi4_0_ar_valid = arValid_q;
   assign io_axi4_0_ar_id    = TXN_ID;
   assign io_axi4_0_ar_addr  = burstAddr_q;
   assign io_axi4_0_ar_len   = 8'(BURST_LEN - 1);
   assign io_axi4_0_ar_size  = 3'b011;
   assign io_axi4_0_ar_burst = 2'b01;
   assign io_axi4_0_ar_lock  = 1'b0;
   assign io_axi4_0_ar_cache = 4'b0011;
   assign io_axi4_0_ar_prot  = 3'b000;
   assign io_axi4_0_ar_qos   = 4'b0000;
   assign io_axi4_0_r_ready  = rReady_q;

   // Test sequencer: one outstanding transaction, valids raised the cycle after entering a state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         burstAddr_q  <= '0;
         burstCnt_q   <= '0;
         beatCnt_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         errorCount_q <= '0;
         firstFail_q  <= '0;
         awValid_q    <= 1'b0;
         wValid_q     <= 1'b0;
         bReady_q     <= 1'b0;
         arValid_q    <= 1'b0;
         rReady_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q      <= WR_AW;
                  burstAddr_q  <= BASE_ADDR;
                  burstCnt_q   <= '0;
                  beatCnt_q    <= '0;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  errorCount_q <= '0;
                  firstFail_q  <= '0;
               end
            end
            WR_AW: begin
               if (!awValid_q) begin
                  awValid_q <= 1'b1;
               end else if (io_axi4_0_aw_ready) begin
                  awValid_q <= 1'b0;
                  state_q   <= WR_W;
               end
            end
            WR_W: begin
               if (!wValid_q) begin
                  wValid_q <= 1'b1;
               end else if (io_axi4_0_w_ready) begin
                  if (isLastBeat) begin
                     wValid_q  <= 1'b0;
                     beatCnt_q <= '0;
                     bReady_q  <= 1'b1;
                     state_q   <= WR_B;
                  end else begin
                     beatCnt_q <= beatCnt_q + 9'd1;
                  end
               end
            end
            WR_B: begin
               if (io_axi4_0_b_valid) begin
                  bReady_q <= 1'b0;
                  if (bBad) begin
                     errorCount_q <= errorCountInc;
                     if (errorCount_q == 16'h0) firstFail_q <= burstAddr_q;
                  end
                  if (moreBursts) begin
                     burstCnt_q  <= burstCnt_q + 32'd1;
                     burstAddr_q <= burstAddr_q + BURST_BYTES;
                     state_q     <= WR_AW;
                  end else begin
                     burstCnt_q  <= '0;
                     burstAddr_q <= BASE_ADDR;
                     state_q     <= RD_AR;
                  end
               end
            end
            RD_AR: begin
               if (!arValid_q) begin
                  arValid_q <= 1'b1;
               end else if (io_axi4_0_ar_ready) begin
                  arValid_q <= 1'b0;
                  rReady_q  <= 1'b1;
                  state_q   <= RD_R;
               end
            end
            RD_R: begin
               if (io_axi4_0_r_valid) begin
                  if (rBad) begin
                     errorCount_q <= errorCountInc;
                     if (errorCount_q == 16'h0) firstFail_q <= beatAddr;
                  end
                  if (io_axi4_0_r_last) begin
                     rReady_q    <= 1'b0;
                     beatCnt_q   <= '0;
                     burstAddr_q <= burstAddr_q + BURST_BYTES;
                     if (moreBursts) begin
                        burstCnt_q <= burstCnt_q + 32'd1;
                        state_q    <= RD_AR;
                     end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (errorCount_q == 16'h0) && !rBad;
                        state_q <= DONE;
                     end
                  end else begin
                     beatCnt_q <= beatCnt_q + 9'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
